// File: rtl/mux_scan_pkg.sv
// Shared definitions for the mux_scan selector.
//
// Contents:
//   state_t      - FSM encoding (manual / scan)
//   MODE_MANUAL  - value of the mode input that selects manual channel choice
//   MODE_SCAN    - value of the mode input that selects round-robin scanning
package mux_scan_pkg;

    typedef enum logic {
        ST_MAN  = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/mux_n_sel.sv
// Combinational N_CH x WIDTH channel selector.
//
// An index that does not name an existing channel yields all-zero data
// and hit=0, so indices N_CH..2**SEL_W-1 are safe to present.
//
// Ports:
//   data  in  N_CH*WIDTH  packed channels, channel k at [k*WIDTH +: WIDTH]
//   idx   in  SEL_W       channel to select
//   out   out WIDTH       selected channel data (0 when out of range)
//   hit   out 1           1 when idx < N_CH
module mux_n_sel #(
    parameter int N_CH  = 7,
    parameter int WIDTH = 1,
    parameter int SEL_W = 3
) (
    input  logic [N_CH*WIDTH-1:0] data,
    input  logic [SEL_W-1:0]      idx,
    output logic [WIDTH-1:0]      out,
    output logic                  hit
);

    always_comb begin
        out = '0;
        hit = 1'b0;
        for (int k = 0; k < N_CH; k++) begin
            if (idx == SEL_W'(k)) begin
                out = data[k*WIDTH +: WIDTH];
                hit = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_scan.sv
// Registered N-channel selector with manual and round-robin scan modes.
//
// In manual mode the channel comes from sel. In scan mode each channel is
// shown for DWELL enabled cycles, wrapping from N_CH-1 back to 0, and
// sweep_done pulses on the final dwell cycle of the last channel.
//
// Ports:
//   clock       in  1           rising-edge clock
//   resetn      in  1           synchronous active-low reset
//   enable      in  1           0 holds every register (sweep_done forced 0)
//   mode        in  1           0 = manual, 1 = scan
//   sel         in  SEL_W       manual channel select
//   data_in     in  N_CH*WIDTH  channel k at [k*WIDTH +: WIDTH]
//   data_out    out WIDTH       registered selected data
//   chan_out    out SEL_W       channel index reflected by data_out
//   chan_valid  out 1           chan_out names an existing channel
//   sweep_done  out 1           end-of-sweep strobe in scan mode
module mux_scan
    import mux_scan_pkg::*;
#(
    parameter int N_CH    = 7,
    parameter int WIDTH   = 1,
    parameter int SEL_W   = 3,
    parameter int DWELL   = 4,
    parameter int DWELL_W = 3
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  enable,
    input  logic                  mode,
    input  logic [SEL_W-1:0]      sel,
    input  logic [N_CH*WIDTH-1:0] data_in,
    output logic [WIDTH-1:0]      data_out,
    output logic [SEL_W-1:0]      chan_out,
    output logic                  chan_valid,
    output logic                  sweep_done
);

    state_t             state;
    state_t             state_next;
    logic [SEL_W-1:0]   idx;
    logic [DWELL_W-1:0] cnt;

    logic [SEL_W-1:0]   eff_idx;
    logic [DWELL_W-1:0] eff_cnt;
    logic [SEL_W-1:0]   pick_idx;
    logic [SEL_W-1:0]   idx_next;
    logic [DWELL_W-1:0] cnt_next;
    logic               last_dwell;
    logic               last_chan;
    logic               scan_now;
    logic [WIDTH-1:0]   pick_data;
    logic               pick_hit;

    // State register.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state <= ST_MAN;
        end else if (enable) begin
            state <= state_next;
        end
    end

    // Next state and scan bookkeeping. The first scan cycle after manual
    // mode behaves as if idx and cnt were zero, so every sweep restarts
    // at channel 0 regardless of what the counters held before.
    always_comb begin
        state_next = state;
        scan_now   = (mode == MODE_SCAN);
        eff_idx    = idx;
        eff_cnt    = cnt;
        if (state == ST_MAN) begin
            eff_idx = '0;
            eff_cnt = '0;
        end

        last_dwell = (eff_cnt == DWELL_W'(DWELL - 1));
        last_chan  = (eff_idx == SEL_W'(N_CH - 1));

        idx_next = eff_idx;
        cnt_next = eff_cnt + DWELL_W'(1);
        if (last_dwell) begin
            cnt_next = '0;
            idx_next = last_chan ? '0 : eff_idx + SEL_W'(1);
        end

        pick_idx   = scan_now ? eff_idx : sel;
        state_next = scan_now ? ST_SCAN : ST_MAN;
    end

    mux_n_sel #(
        .N_CH  (N_CH),
        .WIDTH (WIDTH),
        .SEL_W (SEL_W)
    ) u_sel (
        .data (data_in),
        .idx  (pick_idx),
        .out  (pick_data),
        .hit  (pick_hit)
    );

    // Output and counter registers. idx/cnt only move in scan mode; their
    // value while in manual mode is irrelevant because entry masks them.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            data_out   <= '0;
            chan_out   <= '0;
            chan_valid <= 1'b0;
            sweep_done <= 1'b0;
            idx        <= '0;
            cnt        <= '0;
        end else if (enable) begin
            data_out   <= pick_data;
            chan_out   <= pick_idx;
            chan_valid <= pick_hit;
            sweep_done <= scan_now && last_chan && last_dwell;
            if (scan_now) begin
                idx <= idx_next;
                cnt <= cnt_next;
            end
        end else begin
            sweep_done <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux_scan.sv
// Directed testbench for mux_scan: one instance with DWELL=2 and one with
// DWELL=1, both driven by the same inputs.
module tb_mux_scan;

    logic       clock;
    logic       resetn;
    logic       enable;
    logic       mode;
    logic [2:0] sel;
    logic [6:0] data_in;

    logic       data_out;
    logic [2:0] chan_out;
    logic       chan_valid;
    logic       sweep_done;

    logic       d1_data_out;
    logic [2:0] d1_chan_out;
    logic       d1_chan_valid;
    logic       d1_sweep_done;

    int checks   = 0;
    int failures = 0;

    int exp_chan  [14];
    int exp_data  [14];
    int exp_chan1 [8];

    mux_scan #(
        .N_CH(7), .WIDTH(1), .SEL_W(3), .DWELL(2), .DWELL_W(2)
    ) dut (
        .clock      (clock),
        .resetn     (resetn),
        .enable     (enable),
        .mode       (mode),
        .sel        (sel),
        .data_in    (data_in),
        .data_out   (data_out),
        .chan_out   (chan_out),
        .chan_valid (chan_valid),
        .sweep_done (sweep_done)
    );

    mux_scan #(
        .N_CH(7), .WIDTH(1), .SEL_W(3), .DWELL(1), .DWELL_W(1)
    ) dut1 (
        .clock      (clock),
        .resetn     (resetn),
        .enable     (enable),
        .mode       (mode),
        .sel        (sel),
        .data_in    (data_in),
        .data_out   (d1_data_out),
        .chan_out   (d1_chan_out),
        .chan_valid (d1_chan_valid),
        .sweep_done (d1_sweep_done)
    );

    // Free-running clock, 10 time units per period.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Hard time limit so the bench can never hang.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Drive inputs, then advance one rising edge; outputs are observed 1
    // time unit after that edge.
    task automatic applyStimulus(input logic rn, input logic en, input logic md,
                                 input logic [2:0] s, input logic [6:0] d);
        resetn  = rn;
        enable  = en;
        mode    = md;
        sel     = s;
        data_in = d;
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    initial begin
        logic found;
        exp_chan  = '{0,0,1,1,2,2,3,3,4,4,5,5,6,6};
        exp_data  = '{1,1,0,0,1,1,0,0,0,0,1,1,0,0};
        exp_chan1 = '{0,1,2,3,4,5,6,0};

        resetn = 1'b0; enable = 1'b1; mode = 1'b0; sel = 3'd3; data_in = 7'h7F;
        #2;

        // Reset for two cycles with all data bits high.
        applyStimulus(1'b0, 1'b1, 1'b0, 3'd3, 7'h7F);
        applyStimulus(1'b0, 1'b1, 1'b0, 3'd3, 7'h7F);
        checkOutput("rst_data",  data_out,   0);
        checkOutput("rst_chan",  chan_out,   0);
        checkOutput("rst_valid", chan_valid, 0);
        checkOutput("rst_sweep", sweep_done, 0);

        // Manual selection.
        applyStimulus(1'b1, 1'b1, 1'b0, 3'd2, 7'b1010101);
        checkOutput("man2_data",  data_out,   1);
        checkOutput("man2_chan",  chan_out,   2);
        checkOutput("man2_valid", chan_valid, 1);
        applyStimulus(1'b1, 1'b1, 1'b0, 3'd3, 7'b1010101);
        checkOutput("man3_data",  data_out,   0);
        checkOutput("man3_chan",  chan_out,   3);
        applyStimulus(1'b1, 1'b1, 1'b0, 3'd6, 7'b1010101);
        checkOutput("man6_data",  data_out,   1);
        checkOutput("man6_valid", chan_valid, 1);
        applyStimulus(1'b1, 1'b1, 1'b0, 3'd7, 7'b1010101);
        checkOutput("man7_data",  data_out,   0);
        checkOutput("man7_chan",  chan_out,   7);
        checkOutput("man7_valid", chan_valid, 0);
        checkOutput("man7_sweep", sweep_done, 0);

        // One full scan sweep with DWELL=2.
        for (int i = 0; i < 14; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b1, 3'd7, 7'b0100101);
            checkOutput($sformatf("scan_chan[%0d]", i), chan_out, exp_chan[i]);
            checkOutput($sformatf("scan_data[%0d]", i), data_out, exp_data[i]);
            checkOutput($sformatf("scan_valid[%0d]", i), chan_valid, 1);
            checkOutput($sformatf("scan_sweep[%0d]", i), sweep_done, (i == 13) ? 1 : 0);
        end
        applyStimulus(1'b1, 1'b1, 1'b1, 3'd7, 7'b0100101);
        checkOutput("scan_wrap_chan",  chan_out,   0);
        checkOutput("scan_wrap_sweep", sweep_done, 0);

        // Advance to the first cycle showing channel 3.
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b1, 3'd7, 7'b0100101);
            if (chan_out == 3'd3) found = 1'b1;
        end
        checkOutput("reach_chan3", found, 1);

        // Enable gap: outputs freeze, then one more dwell cycle on 3.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b1, 3'd7, 7'b0100101);
            checkOutput($sformatf("gap_chan[%0d]", i), chan_out, 3);
            checkOutput($sformatf("gap_sweep[%0d]", i), sweep_done, 0);
        end
        applyStimulus(1'b1, 1'b1, 1'b1, 3'd7, 7'b0100101);
        checkOutput("gap_resume3", chan_out, 3);
        applyStimulus(1'b1, 1'b1, 1'b1, 3'd7, 7'b0100101);
        checkOutput("gap_next4", chan_out, 4);

        // Mode toggle mid-dwell on channel 4, then scan restarts at 0.
        applyStimulus(1'b1, 1'b1, 1'b0, 3'd5, 7'b0100101);
        checkOutput("tog_man_chan", chan_out, 5);
        checkOutput("tog_man_data", data_out, 1);
        applyStimulus(1'b1, 1'b1, 1'b1, 3'd5, 7'b0100101);
        checkOutput("tog_scan0a", chan_out, 0);
        applyStimulus(1'b1, 1'b1, 1'b1, 3'd5, 7'b0100101);
        checkOutput("tog_scan0b", chan_out, 0);
        applyStimulus(1'b1, 1'b1, 1'b1, 3'd5, 7'b0100101);
        checkOutput("tog_scan1", chan_out, 1);

        // DWELL=1 instance: fresh entry, advance every cycle.
        applyStimulus(1'b1, 1'b1, 1'b0, 3'd0, 7'b0100101);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b1, 3'd0, 7'b0100101);
            checkOutput($sformatf("d1_chan[%0d]", i), d1_chan_out, exp_chan1[i]);
            checkOutput($sformatf("d1_sweep[%0d]", i), d1_sweep_done, (i == 6) ? 1 : 0);
        end

        // Reset mid-scan at channel 2 on the DWELL=2 instance.
        applyStimulus(1'b1, 1'b1, 1'b0, 3'd0, 7'b0100101);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b1, 3'd0, 7'b0100101);
        end
        checkOutput("pre_rst_chan", chan_out, 2);
        applyStimulus(1'b0, 1'b1, 1'b1, 3'd0, 7'b0100101);
        checkOutput("midrst_data",  data_out,   0);
        checkOutput("midrst_chan",  chan_out,   0);
        checkOutput("midrst_valid", chan_valid, 0);
        checkOutput("midrst_sweep", sweep_done, 0);
        applyStimulus(1'b1, 1'b1, 1'b1, 3'd0, 7'b0100101);
        checkOutput("post_rst_chan",  chan_out,   0);
        checkOutput("post_rst_data",  data_out,   1);
        checkOutput("post_rst_valid", chan_valid, 1);
        applyStimulus(1'b1, 1'b1, 1'b1, 3'd0, 7'b0100101);
        checkOutput("post_rst_chan0b", chan_out, 0);
        applyStimulus(1'b1, 1'b1, 1'b1, 3'd0, 7'b0100101);
        checkOutput("post_rst_chan1", chan_out, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
